lfsr_seq_ctrl: RTL and testbench

Self-contained pseudo-random word generator: a Fibonacci LFSR built from WIDTH per-bit node cells plus the controller that sequences them. Accepts a seed and a beat count, loads the seed, then streams successive LFSR states over a valid/ready interface until the count is exhausted or the run is aborted. Sits between the configuration/register layer and any downstream consumer of test patterns.

---
 rtl/lfsr_pkg.sv | 34 +++
 rtl/lfsr_seq_ctrl_node.sv | 45 ++++
 rtl/lfsr_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_lfsr_seq_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_pkg
// Description : Shared definitions for the LFSR pattern generator: controller
//               state encoding, default geometry constants and the Fibonacci
//               feedback helper.
// Revision    : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

    localparam int          DEF_WIDTH = 16;
    localparam logic [15:0] DEF_TAPS  = 16'hB400;   // x^16+x^14+x^13+x^11+1
    localparam int          DEF_CNT_W = 16;

    // Widest LFSR the feedback helper supports; narrower states are
    // zero-extended by the caller, which leaves the XOR result unchanged.
    localparam int          MAX_W     = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Feedback bit of a Fibonacci LFSR: parity of the tapped state bits.
    // The next state is {state[W-2:0], lfsr_fb(state, taps)}.
    function automatic logic lfsr_fb(input logic [MAX_W-1:0] state,
                                     input logic [MAX_W-1:0] taps);
        return ^(state & taps);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_seq_ctrl_node.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_seq_ctrl_node
// Description : One bit of the LFSR register. Load has priority, enable
//               takes d, and with neither asserted the bit clears to 0.
// Ports       : clk, reset_n  - clock, async active-low reset
//               ld, seed      - parallel load of the seed bit (priority)
//               en, d         - load of the next-state bit
//               q             - registered bit value
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_seq_ctrl_node (
    input  logic clk,
    input  logic reset_n,
    input  logic ld,
    input  logic en,
    input  logic seed,
    input  logic d,
    output logic q
);

    logic q_d;
    logic q_q;

    always_comb begin
        q_d = 1'b0;
        if (ld) begin
            q_d = seed;
        end else if (en) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/lfsr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_seq_ctrl
// Description : Seeded Fibonacci LFSR pattern generator. Captures a seed and a
//               beat count on start, loads the seed into the bit cells, then
//               streams successive LFSR states over valid/ready until the
//               count runs out (done pulse) or stop aborts the run.
// Ports       : clk, reset_n        - clock, async active-low reset
//               start, stop         - run request (IDLE) / abort (RUN)
//               cfg_seed, cfg_len   - seed and beat count, taken on start
//               out_ready           - downstream ready
//               out_valid, out_data - output stream
//               busy, done          - activity flag / completion pulse
//               err_zero_seed       - pulse when start carries a zero seed
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_seq_ctrl
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS),
    parameter int               CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] cfg_seed,
    input  logic [CNT_W-1:0] cfg_len,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             done,
    output logic             err_zero_seed
);

    state_e           state_d, state_q;
    logic [WIDTH-1:0] seed_d, seed_q;
    logic [CNT_W-1:0] remaining_d, remaining_q;
    logic             valid_d, valid_q;
    logic             busy_d, busy_q;
    logic             done_d, done_q;
    logic             err_d, err_q;

    logic             cell_ld;
    logic             cell_en;
    logic [WIDTH-1:0] cell_d;
    logic [WIDTH-1:0] cell_q;
    logic [WIDTH-1:0] lfsr_next;

    assign lfsr_next = {cell_q[WIDTH-2:0],
                        lfsr_fb(MAX_W'(cell_q), MAX_W'(TAPS))};

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_node
            lfsr_seq_ctrl_node u_node (
                .clk     (clk),
                .reset_n (reset_n),
                .ld      (cell_ld),
                .en      (cell_en),
                .seed    (seed_q[gi]),
                .d       (cell_d[gi]),
                .q       (cell_q[gi])
            );
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        seed_d      = seed_q;
        remaining_d = remaining_q;
        err_d       = 1'b0;
        // Cells clear unless explicitly loaded or held.
        cell_ld     = 1'b0;
        cell_en     = 1'b0;
        cell_d      = cell_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_seed == '0) begin
                        err_d = 1'b1;
                    end else if (cfg_len == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        seed_d      = cfg_seed;
                        remaining_d = cfg_len;
                        state_d     = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                cell_ld = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // Hold is en=1 with d=q; advance only on a handshake.
                cell_en = 1'b1;
                if (out_ready) begin
                    cell_d      = lfsr_next;
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
                // Abort overrides completion; a same-cycle handshake has
                // already been presented and is treated as delivered.
                if (stop) begin
                    state_d     = ST_IDLE;
                    remaining_d = '0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are registered copies of the upcoming state.
        valid_d = (state_d == ST_RUN);
        busy_d  = (state_d == ST_LOAD) || (state_d == ST_RUN);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            seed_q      <= '0;
            remaining_q <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            remaining_q <= remaining_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign out_valid     = valid_q;
    // Cells may still hold a stale advanced value on the cycle after a run
    // ends, so data is forced to zero whenever it is not valid.
    assign out_data      = valid_q ? cell_q : '0;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err_zero_seed = err_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_seq_ctrl
// Description : Self-checking bench for lfsr_seq_ctrl: table of seeded runs
//               with hand-computed beats, plus directed stall, error, abort
//               and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_seq_ctrl;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        stop;
    logic [15:0] cfg_seed;
    logic [15:0] cfg_len;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        busy;
    logic        done;
    logic        err_zero_seed;

    int errors = 0;
    int checks = 0;

    lfsr_seq_ctrl dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .stop          (stop),
        .cfg_seed      (cfg_seed),
        .cfg_len       (cfg_len),
        .out_ready     (out_ready),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .busy          (busy),
        .done          (done),
        .err_zero_seed (err_zero_seed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]      seed;
        logic [15:0]      len;
        logic [3:0][15:0] beats;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full run with ready held high; checks every beat and the done timing.
    task automatic run_vec(input vec_t v);
        start    = 1'b1;
        cfg_seed = v.seed;
        cfg_len  = v.len;
        step();
        start    = 1'b0;
        cfg_seed = 16'hFFFF;       // later cfg changes must have no effect
        cfg_len  = 16'h0007;
        check("load_busy", {31'd0, busy}, 32'd1);
        check("load_valid", {31'd0, out_valid}, 32'd0);
        for (int k = 0; k < int'(v.len); k++) begin
            step();
            check("beat_valid", {31'd0, out_valid}, 32'd1);
            check("beat_data", {16'd0, out_data}, {16'd0, v.beats[k]});
        end
        step();
        check("done_pulse", {31'd0, done}, 32'd1);
        check("done_valid", {31'd0, out_valid}, 32'd0);
        check("done_busy", {31'd0, busy}, 32'd0);
        step();
        check("done_clear", {31'd0, done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs [4];
        logic [15:0] stall_exp [4];
        int k;
        int cyc;

        vecs[0] = '{seed: 16'h0001, len: 16'd3,
                    beats: {16'h0000, 16'h0004, 16'h0002, 16'h0001}};
        vecs[1] = '{seed: 16'hACE1, len: 16'd2,
                    beats: {16'h0000, 16'h0000, 16'h59C3, 16'hACE1}};
        vecs[2] = '{seed: 16'h8000, len: 16'd2,
                    beats: {16'h0000, 16'h0000, 16'h0001, 16'h8000}};
        vecs[3] = '{seed: 16'hACE1, len: 16'd4,
                    beats: {16'h670F, 16'hB387, 16'h59C3, 16'hACE1}};
        stall_exp = '{16'hACE1, 16'h59C3, 16'hB387, 16'h670F};

        reset_n   = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        cfg_seed  = 16'h0000;
        cfg_len   = 16'h0000;
        out_ready = 1'b1;
        step();
        step();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {16'd0, out_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err_zero_seed}, 32'd0);
        reset_n = 1'b1;
        step();

        // Table of full runs with sustained ready.
        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i]);
        end

        // Stalled run: ready pattern 1,0,0,1 repeating.
        start    = 1'b1;
        cfg_seed = 16'hACE1;
        cfg_len  = 16'd4;
        step();
        start = 1'b0;
        step();                     // first RUN cycle
        k   = 0;
        cyc = 0;
        while (k < 4 && cyc < 30) begin
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_data", {16'd0, out_data}, {16'd0, stall_exp[k]});
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            if (out_ready) k++;
            cyc++;
            step();
        end
        check("stall_beats", k, 32'd4);
        check("stall_done", {31'd0, done}, 32'd1);
        out_ready = 1'b1;
        step();

        // Zero seed is rejected.
        start    = 1'b1;
        cfg_seed = 16'h0000;
        cfg_len  = 16'd5;
        step();
        start = 1'b0;
        check("zs_err", {31'd0, err_zero_seed}, 32'd1);
        check("zs_busy", {31'd0, busy}, 32'd0);
        step();
        check("zs_err_clear", {31'd0, err_zero_seed}, 32'd0);
        check("zs_busy2", {31'd0, busy}, 32'd0);

        // Zero length completes immediately with no beats.
        start    = 1'b1;
        cfg_seed = 16'h1234;
        cfg_len  = 16'd0;
        step();
        start = 1'b0;
        check("zl_done", {31'd0, done}, 32'd1);
        check("zl_busy", {31'd0, busy}, 32'd0);
        check("zl_valid", {31'd0, out_valid}, 32'd0);
        step();
        check("zl_done_clear", {31'd0, done}, 32'd0);
        check("zl_valid2", {31'd0, out_valid}, 32'd0);

        // Abort after the third beat.
        start    = 1'b1;
        cfg_seed = 16'h0001;
        cfg_len  = 16'd10;
        step();
        start = 1'b0;
        step();
        check("ab_beat0", {16'd0, out_data}, 32'h0001);
        step();
        check("ab_beat1", {16'd0, out_data}, 32'h0002);
        step();
        check("ab_beat2", {16'd0, out_data}, 32'h0004);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("ab_valid", {31'd0, out_valid}, 32'd0);
        check("ab_data", {16'd0, out_data}, 32'd0);
        check("ab_busy", {31'd0, busy}, 32'd0);
        check("ab_nodone", {31'd0, done}, 32'd0);
        step();
        check("ab_nodone2", {31'd0, done}, 32'd0);
        run_vec(vecs[0]);

        // start ignored in RUN, async reset mid-run.
        start    = 1'b1;
        cfg_seed = 16'hACE1;
        cfg_len  = 16'd10;
        step();
        start = 1'b0;
        step();
        check("rr_beat0", {16'd0, out_data}, 32'hACE1);
        start    = 1'b1;
        cfg_seed = 16'h0001;
        cfg_len  = 16'd1;
        step();
        check("rr_beat1", {16'd0, out_data}, 32'h59C3);
        start = 1'b0;
        step();
        check("rr_beat2", {16'd0, out_data}, 32'hB387);
        check("rr_busy", {31'd0, busy}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rr_valid", {31'd0, out_valid}, 32'd0);
        check("rr_data", {16'd0, out_data}, 32'd0);
        check("rr_busy0", {31'd0, busy}, 32'd0);
        check("rr_done", {31'd0, done}, 32'd0);
        step();
        reset_n = 1'b1;
        step();
        check("rr_done2", {31'd0, done}, 32'd0);

        // stop in IDLE ignored: start with stop still accepted.
        start    = 1'b1;
        stop     = 1'b1;
        cfg_seed = 16'h8000;
        cfg_len  = 16'd2;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check("si_busy", {31'd0, busy}, 32'd1);
        step();
        check("si_beat0", {16'd0, out_data}, 32'h8000);
        step();
        check("si_beat1", {16'd0, out_data}, 32'h0001);
        step();
        check("si_done", {31'd0, done}, 32'd1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
